// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider: default divisor width and the
// smallest divisor the counter will ever run with.
package clock_divider_pkg;

   localparam int DIV_WIDTH_DEFAULT = 16;
   localparam int MIN_DIV           = 1;

endpackage

// File: rtl/clock_divider.sv
// Divides clk_in by 2*max(div,1) with a 50% duty, flop-driven clk_out.
// Defining CLOCKDIV_TICK_EN adds a one-cycle tick on every clk_out rise.
module clock_divider
   import clock_divider_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 clk_out
`ifdef CLOCKDIV_TICK_EN
   ,
   output logic                 tick
`endif
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic                 clk_out_q, clk_out_d;
   logic [DIV_WIDTH-1:0] div_eff;
   logic                 wrap;
   logic                 rise;

   always_comb begin
      // A stored divisor of 0 runs exactly like MIN_DIV.
      div_eff   = (div_q < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_q;
      wrap      = (cnt_q == (div_eff - DIV_WIDTH'(1)));
      rise      = wrap && !clk_out_q;
      cnt_d     = wrap ? '0 : (cnt_q + DIV_WIDTH'(1));
      clk_out_d = wrap ? ~clk_out_q : clk_out_q;
      // The divisor is only picked up at a rising edge so a full period
      // never mixes two divisor values.
      div_d     = rise ? div : div_q;
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         div_q     <= div;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         div_q     <= div_d;
      end
   end

   assign clk_out = clk_out_q;

`ifdef CLOCKDIV_TICK_EN
   logic tick_q, tick_d;

   always_comb begin
      tick_d = rise;
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: a half-period countdown model checked every cycle
// plus directed latency/phase-length checks. Honours CLOCKDIV_TICK_EN.
module tb_clock_divider;

   localparam int W = 16;

   logic         clk_in;
   logic         reset;
   logic [W-1:0] div;
   logic         clk_out;
`ifdef CLOCKDIV_TICK_EN
   logic         tick;
`endif

   int n_vec;
   int n_err;

   clock_divider #(.DIV_WIDTH(W)) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .div     (div),
      .clk_out (clk_out)
`ifdef CLOCKDIV_TICK_EN
      ,
      .tick    (tick)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // ---------------- behavioural model ----------------
   // Level, cycles left in the current half period, and the divisor in use.
   logic [1:0] exp_q[$];
   bit         m_valid = 1'b0;
   bit         m_lvl;
   bit         m_tick;
   int         m_cur;
   int         m_rem;

   function automatic int eff(input logic [W-1:0] d);
      return (d == 0) ? 1 : int'(d);
   endfunction

   always @(posedge clk_in) begin
      if (!reset) begin
         m_valid = 1'b1;
         m_lvl   = 1'b0;
         m_tick  = 1'b0;
         m_cur   = eff(div);
         m_rem   = m_cur;
      end else if (m_valid) begin
         m_tick = 1'b0;
         m_rem  = m_rem - 1;
         if (m_rem == 0) begin
            m_lvl = !m_lvl;
            if (m_lvl) begin
               m_cur  = eff(div);
               m_tick = 1'b1;
            end
            m_rem = m_cur;
         end
      end
      if (m_valid) exp_q.push_back({m_tick, m_lvl});
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard compare ----------------
   always @(posedge clk_in) begin
      logic [1:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("clk_out_model", int'(clk_out), int'(e[0]));
`ifdef CLOCKDIV_TICK_EN
         check("tick_model", int'(tick), int'(e[1]));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int n, input logic [W-1:0] d);
      @(negedge clk_in);
      reset = 1'b0;
      div   = d;
      repeat (n) @(negedge clk_in);
      check("clk_out_in_reset", int'(clk_out), 0);
`ifdef CLOCKDIV_TICK_EN
      check("tick_in_reset", int'(tick), 0);
`endif
      reset = 1'b1;
   endtask

   // Counts clk_in edges until clk_out leaves its current level.
   task automatic run_len(input string name, input int exp);
      logic lvl;
      int   k;
      bit   done;
      lvl  = clk_out;
      k    = 0;
      done = 1'b0;
      while (!done && k < 70000) begin
         @(posedge clk_in);
         #1;
         k++;
         if (clk_out != lvl) done = 1'b1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: timeout after %0d edges, expected %0d", name, k, exp);
      end else begin
         check(name, k, exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      div   = '0;

      // div=1: divide-by-2
      do_reset(4, 16'd1);
      run_len("div1_first_rise", 1);
      run_len("div1_high", 1);
      run_len("div1_low", 1);

      // div=3
      do_reset(4, 16'd3);
      run_len("div3_first_rise", 3);
      run_len("div3_high", 3);
      run_len("div3_low", 3);
      run_len("div3_high2", 3);

      // div=0 behaves as 1
      do_reset(3, 16'd0);
      run_len("div0_first_rise", 1);
      run_len("div0_high", 1);
      run_len("div0_low", 1);

      // div 2 -> 5 changed during a high phase
      do_reset(2, 16'd2);
      run_len("chg_first_rise", 2);
      @(negedge clk_in);
      div = 16'd5;
      run_len("chg_old_high", 2);
      run_len("chg_old_low", 2);
      run_len("chg_new_high", 5);
      run_len("chg_new_low", 5);

      // 1-cycle reset pulse mid high phase, div=4
      do_reset(2, 16'd4);
      run_len("rst_first_rise", 4);
      @(posedge clk_in);
      #1;
      check("rst_still_high", int'(clk_out), 1);
      @(negedge clk_in);
      reset = 1'b0;
      @(posedge clk_in);
      #1;
      check("rst_forces_low", int'(clk_out), 0);
      @(negedge clk_in);
      reset = 1'b1;
      run_len("rst_restart_rise", 4);

      // randomized divisor changes and reset pulses
      for (int i = 0; i < 800; i++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 15) == 0) div = W'($urandom_range(0, 6));
         reset = ($urandom_range(0, 60) != 0);
      end

      // widest divisor: first rise after 65535 edges, no overflow
      do_reset(2, 16'd65535);
      run_len("div65535_first_rise", 65535);

      @(negedge clk_in);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter DIV_WIDTH, default 16, SHALL set the width of the division input and internal counter.
REQ-002 Port clk_in  input  1  SHALL be the single reference clock; all logic is on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 Port div  input  DIV_WIDTH  SHALL be the half-period length of clk_out in clk_in cycles.
REQ-005 Port clk_out  output  1  SHALL be the divided clock, driven directly from a flop (glitch-free).
REQ-006 Port tick  output  1  SHALL exist only when CLOCKDIV_TICK_EN is defined (see Configuration).

Function
REQ-007 Effective divisor SHALL be div_eff = max(div_q, 1); div value 0 behaves exactly as 1.
REQ-008 Internal register div_q SHALL hold the divisor in use; the live div input SHALL never affect an ongoing period.
REQ-009 Internal counter cnt (DIV_WIDTH bits) SHALL increment by 1 on each clk_in edge while out of reset.
REQ-010 When cnt == div_eff-1, the next edge SHALL clear cnt to 0 and invert clk_out.
REQ-011 Each clk_out half-period SHALL be exactly div_eff clk_in cycles; full period 2*div_eff; duty 50%.
REQ-012 div_q SHALL load from div on the same edge at which clk_out toggles 0->1, so each full period (rise to rise) uses a single divisor.
REQ-013 div=1 SHALL give clk_out = clk_in/2 (e.g. 20 MHz -> 10 MHz); div=65535 SHALL give period 131070 cycles, no overflow.
REQ-014 First clk_out rising edge after reset release SHALL occur on the div_eff-th clk_in edge sampling reset=1.
REQ-015 A div change mid-period SHALL take effect at the next clk_out rising edge; the current high and low phases complete with the old value.
REQ-016 No combinational path SHALL exist from div or reset to clk_out.

Reset
REQ-017 While reset is low at a clk_in edge: clk_out<=0, cnt<=0, div_q<=div, tick<=0.
REQ-018 Reset asserted mid-period SHALL force clk_out low on the next edge, abandoning the partial period.
REQ-019 Holding reset low SHALL keep clk_out low continuously.

Configuration
REQ-020 Macro CLOCKDIV_TICK_EN defined: tick SHALL pulse high for exactly one clk_in cycle, registered, coincident with each clk_out 0->1 transition (same edge).
REQ-021 Macro CLOCKDIV_TICK_EN undefined: the tick port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-022 Package clock_divider_pkg SHALL hold DIV_WIDTH default (16) and MIN_DIV constant (1).
REQ-023 The block SHALL be one flat module; no sub-module.

Verification
REQ-024 div=1, reset low 4 cycles then high -> clk_out rises on 1st edge after release, toggles every cycle, period 2.
REQ-025 div=3 -> clk_out high 3 / low 3 cycles repeatedly; first rise on 3rd edge after release.
REQ-026 div=0 -> identical waveform to div=1.
REQ-027 div=2 running, change to 5 mid high phase -> that high and following low remain 2 cycles; from next rise, 5/5.
REQ-028 Reset pulsed low for 1 cycle mid high phase with div=4 -> clk_out low next edge; restarts with first rise 4 edges after release.
REQ-029 CLOCKDIV_TICK_EN defined, div=2 -> tick high 1 cycle every 4 cycles, aligned with each clk_out rise; never high during reset.
